// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG scan master: TAP state encoding,
// control FSM states, TMS walk paths and the TAP next-state function.
package jtag_pkg;

    // IEEE 1149.1 TAP controller states
    typedef enum logic [3:0] {
        TapTestLogicReset,
        TapRunTestIdle,
        TapSelectDr,
        TapCaptureDr,
        TapShiftDr,
        TapExit1Dr,
        TapPauseDr,
        TapExit2Dr,
        TapUpdateDr,
        TapSelectIr,
        TapCaptureIr,
        TapShiftIr,
        TapExit1Ir,
        TapPauseIr,
        TapExit2Ir,
        TapUpdateIr
    } tap_state_e;

    // Scan master control states
    typedef enum logic [2:0] {
        StInitRst,
        StInitRti,
        StIdle,
        StWalkIn,
        StShift,
        StWalkOut,
        StDone
    } scan_state_e;

    // TMS values from Run-Test/Idle to the Shift state, LSB is the first period
    localparam logic [2:0] TMS_TO_SHIFT_DR = 3'b001;
    localparam logic [3:0] TMS_TO_SHIFT_IR = 4'b0011;

    localparam int unsigned TAP_RESET_CYCLES = 5;

    // Number of walk-in periods from RTI to Shift-DR/IR
    function automatic logic [2:0] walk_in_len(input logic ir);
        return ir ? 3'd4 : 3'd3;
    endfunction

    // TMS value for a given walk-in period
    function automatic logic walk_in_tms(input logic ir, input logic [1:0] step);
        logic [3:0] path;
        path = ir ? TMS_TO_SHIFT_IR : {1'b0, TMS_TO_SHIFT_DR};
        return path[step];
    endfunction

    // TAP transition taken on a rising TCK
    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        n = s;
        unique case (s)
            TapTestLogicReset: n = tms ? TapTestLogicReset : TapRunTestIdle;
            TapRunTestIdle:    n = tms ? TapSelectDr       : TapRunTestIdle;
            TapSelectDr:       n = tms ? TapSelectIr       : TapCaptureDr;
            TapCaptureDr:      n = tms ? TapExit1Dr        : TapShiftDr;
            TapShiftDr:        n = tms ? TapExit1Dr        : TapShiftDr;
            TapExit1Dr:        n = tms ? TapUpdateDr       : TapPauseDr;
            TapPauseDr:        n = tms ? TapExit2Dr        : TapPauseDr;
            TapExit2Dr:        n = tms ? TapUpdateDr       : TapShiftDr;
            TapUpdateDr:       n = tms ? TapSelectDr       : TapRunTestIdle;
            TapSelectIr:       n = tms ? TapTestLogicReset : TapCaptureIr;
            TapCaptureIr:      n = tms ? TapExit1Ir        : TapShiftIr;
            TapShiftIr:        n = tms ? TapExit1Ir        : TapShiftIr;
            TapExit1Ir:        n = tms ? TapUpdateIr       : TapPauseIr;
            TapPauseIr:        n = tms ? TapExit2Ir        : TapPauseIr;
            TapExit2Ir:        n = tms ? TapUpdateIr       : TapShiftIr;
            TapUpdateIr:       n = tms ? TapSelectDr       : TapRunTestIdle;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: low phase of CLK_DIV ICLK cycles, then high phase of CLK_DIV cycles.
// The strobes mark the ICLK cycle whose closing edge moves tck (rise or fall).
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic ICLK,
    input  logic rst,
    input  logic run,
    output logic tck,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tck_q, tck_d;
    logic             phase_end;

    assign phase_end = run & (cnt_q == CNT_MAX);
    assign rise_tick = phase_end & ~tck_q;
    assign fall_tick = phase_end & tck_q;
    assign tck       = tck_q;

    // Phase counter; idles with tck low so the next run starts a fresh low phase
    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!run) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            tck_d = ~tck_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Divider state register
    always_ff @(posedge ICLK) begin
        if (rst) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule

// File: rtl/jtag_scan_master.sv
// Host-side JTAG initiator: turns one IR/DR scan command into a full TAP walk
// RTI -> Shift -> Update -> RTI, returning the captured TDO bits.
module jtag_scan_master
    import jtag_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               ICLK,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_ir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    scan_state_e        state_q, state_d;
    logic [LEN_W-1:0]   step_q, step_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               ir_q, ir_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               cmd_act_q, cmd_act_d;
    tap_state_e         tap_q;

    logic               run, fall_tick, rise_tick;
    logic [LEN_W-1:0]   len_clamped;

    assign len_clamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    assign run = state_q inside {StInitRst, StInitRti, StWalkIn, StShift, StWalkOut};

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

    jtag_tck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tck_gen (
        .ICLK     (ICLK),
        .rst      (rst),
        .run      (run),
        .tck      (tck),
        .fall_tick(fall_tick),
        .rise_tick(rise_tick)
    );

    // Control FSM: tms/tdi for the next period are loaded on the falling TCK edge
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        ir_d        = ir_q;
        len_d       = len_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        cmd_act_d   = cmd_act_q;

        unique case (state_q)
            StInitRst: begin
                if (fall_tick) begin
                    if (step_q == LEN_W'(TAP_RESET_CYCLES - 1)) begin
                        state_d = StInitRti;
                        step_d  = '0;
                        tms_d   = 1'b0;
                    end else begin
                        step_d = step_q + LEN_W'(1);
                    end
                end
            end
            StInitRti: begin
                if (fall_tick) begin
                    state_d = StDone;
                end
            end
            StIdle: begin
                if (cmd_valid) begin
                    ir_d       = cmd_ir;
                    len_d      = len_clamped;
                    data_d     = cmd_data;
                    rsp_data_d = '0;
                    cmd_act_d  = 1'b1;
                    step_d     = '0;
                    tdi_d      = 1'b0;
                    if (len_clamped == '0) begin
                        // Nothing to shift: TAP stays in RTI, answer right away
                        state_d = StDone;
                    end else begin
                        state_d = StWalkIn;
                        tms_d   = walk_in_tms(cmd_ir, 2'd0);
                    end
                end
            end
            StWalkIn: begin
                if (fall_tick) begin
                    if (step_q == LEN_W'(walk_in_len(ir_q)) - LEN_W'(1)) begin
                        state_d = StShift;
                        step_d  = '0;
                        tms_d   = (len_q == LEN_W'(1));
                        tdi_d   = data_q[0];
                    end else begin
                        step_d = step_q + LEN_W'(1);
                        tms_d  = walk_in_tms(ir_q, step_q[1:0] + 2'd1);
                    end
                end
            end
            StShift: begin
                if (rise_tick) begin
                    rsp_data_d = rsp_data_q | (MAX_LEN'(tdo) << step_q);
                end
                if (fall_tick) begin
                    data_d = data_q >> 1;
                    if (step_q == len_q - LEN_W'(1)) begin
                        state_d = StWalkOut;
                        step_d  = '0;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                    end else begin
                        step_d = step_q + LEN_W'(1);
                        // Last shift bit carries tms=1 to leave via Exit1
                        tms_d  = (step_q + LEN_W'(2) == len_q);
                        tdi_d  = data_q[1];
                    end
                end
            end
            StWalkOut: begin
                if (fall_tick) begin
                    tms_d = 1'b0;
                    if (step_q == LEN_W'(1)) begin
                        state_d = StDone;
                        step_d  = '0;
                    end else begin
                        step_d = LEN_W'(1);
                    end
                end
            end
            StDone: begin
                // Only a real command produces a response; init ends here silently
                state_d     = StIdle;
                rsp_valid_d = cmd_act_q;
                cmd_act_d   = 1'b0;
            end
            default: state_d = StInitRst;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge ICLK) begin
        if (rst) begin
            state_q     <= StInitRst;
            step_q      <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            ir_q        <= 1'b0;
            len_q       <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            cmd_act_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            ir_q        <= ir_d;
            len_q       <= len_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_act_q   <= cmd_act_d;
        end
    end

    // Mirror of the target TAP, stepped on every rising TCK
    always_ff @(posedge ICLK) begin
        if (rst) begin
            tap_q <= TapTestLogicReset;
        end else if (rise_tick) begin
            tap_q <= tap_next(tap_q, tms_q);
        end
    end

    // The target must be parked in RTI whenever a new command can be taken
    always_ff @(posedge ICLK) begin
        if (!rst && cmd_ready) begin
            assert (tap_q == TapRunTestIdle);
        end
    end

endmodule
